// File: rtl/node_scheduler.sv
// node_scheduler: autonomous duty-cycle sequencer for the node controller.
// Each sample tick runs READ_SENSOR then WRITE_MEMORY; a full batch is
// flushed as READ_MEMORY/WRITE_RADIO pairs; radio receive is serviced
// between sample jobs. Every op is a REQ -> RUN -> GAP handshake on busy.
module node_scheduler #(
  parameter int unsigned SAMPLE_PERIOD = 1000,
  parameter int unsigned BATCH         = 4,
  parameter int unsigned TIMER_W       = 16,
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_i,
  input  logic       rx_pending_i,
  input  logic       clear_err_i,
  input  logic       ctrl_busy_i,
  output logic       ctrl_enable_o,
  output logic [2:0] ctrl_inst_o,
  output logic       sched_busy_o,
  output logic [7:0] stored_cnt_o,
  output logic       batch_sent_o,
  output logic       overrun_o,
  output logic       timeout_err_o
);

  localparam logic [2:0] INST_IDLE         = 3'b000;
  localparam logic [2:0] INST_READ_SENSOR  = 3'b001;
  localparam logic [2:0] INST_READ_RADIO   = 3'b010;
  localparam logic [2:0] INST_WRITE_RADIO  = 3'b011;
  localparam logic [2:0] INST_WRITE_MEMORY = 3'b100;
  localparam logic [2:0] INST_READ_MEMORY  = 3'b101;

  localparam int unsigned TO_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(SAMPLE_PERIOD - 1);
  localparam logic [TO_W-1:0]    TO_LAST      = TO_W'(START_TIMEOUT - 1);
  localparam logic [7:0]         BATCH_CNT    = 8'(BATCH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SENSE,
    ST_STORE,
    ST_FETCH,
    ST_SEND,
    ST_RECV
  } state_e;

  typedef enum logic [1:0] {
    PH_REQ,
    PH_RUN,
    PH_GAP
  } phase_e;

  state_e state_q, state_d;
  state_e resume_q, resume_d;
  state_e nextOp;
  phase_e phase_q, phase_d;

  logic [TO_W-1:0]    toCnt_q, toCnt_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               tick;
  logic               tickPend_q, tickPend_d;
  logic               enterSense;
  logic               timeoutSet;
  logic               overrunSet;
  logic [7:0]         storedCnt_q, storedCnt_d;
  logic               batchSent_q, batchSent_d;
  logic               overrun_q, overrun_d;
  logic               timeoutErr_q, timeoutErr_d;
  logic               ctrlEnable_q, ctrlEnable_d;
  logic               schedBusy_q, schedBusy_d;
  logic [2:0]         ctrlInst_q, ctrlInst_d;

  // Instruction code carried by each working state.
  function automatic logic [2:0] opCode(input state_e s);
    logic [2:0] code;
    case (s)
      ST_SENSE: code = INST_READ_SENSOR;
      ST_STORE: code = INST_WRITE_MEMORY;
      ST_FETCH: code = INST_READ_MEMORY;
      ST_SEND:  code = INST_WRITE_RADIO;
      ST_RECV:  code = INST_READ_RADIO;
      default:  code = INST_IDLE;
    endcase
    return code;
  endfunction

  // Sample timer: counts down while running, reloads and ticks at zero.
  always_comb begin
    tick    = 1'b0;
    timer_d = timer_q;
    if (run_i) begin
      if (timer_q == '0) begin
        timer_d = TIMER_RELOAD;
        tick    = 1'b1;
      end else begin
        timer_d = timer_q - 1'b1;
      end
    end
  end

  // Main job sequencer: dispatch from IDLE, REQ/RUN/GAP handshake per op.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    toCnt_d     = toCnt_q;
    resume_d    = resume_q;
    storedCnt_d = storedCnt_q;
    batchSent_d = 1'b0;
    timeoutSet  = 1'b0;
    enterSense  = 1'b0;
    nextOp      = ST_IDLE;

    case (state_q)
      ST_IDLE: begin
        phase_d = PH_REQ;
        toCnt_d = '0;
        if (run_i) begin
          if (resume_q != ST_IDLE) begin
            state_d = resume_q;
          end else if (tickPend_q) begin
            state_d    = ST_SENSE;
            enterSense = 1'b1;
          end else if (rx_pending_i) begin
            state_d = ST_RECV;
          end
        end
      end

      default: begin
        case (phase_q)
          PH_REQ: begin
            if (ctrl_busy_i) begin
              phase_d = PH_RUN;
            end else if (toCnt_q == TO_LAST) begin
              timeoutSet = 1'b1;
              state_d    = ST_IDLE;
              phase_d    = PH_REQ;
              toCnt_d    = '0;
            end else begin
              toCnt_d = toCnt_q + 1'b1;
            end
          end

          PH_RUN: begin
            if (!ctrl_busy_i) begin
              phase_d = PH_GAP;
            end
          end

          PH_GAP: begin
            case (state_q)
              ST_SENSE: nextOp = ST_STORE;
              ST_STORE: begin
                if (storedCnt_q != 8'hFF) begin
                  storedCnt_d = storedCnt_q + 8'd1;
                end
                if (storedCnt_d == BATCH_CNT) begin
                  resume_d = ST_FETCH;
                  nextOp   = ST_FETCH;
                end
              end
              ST_FETCH: begin
                resume_d = ST_SEND;
                nextOp   = ST_SEND;
              end
              ST_SEND: begin
                if (storedCnt_q != 8'd0) begin
                  storedCnt_d = storedCnt_q - 8'd1;
                end
                if (storedCnt_d == 8'd0) begin
                  resume_d    = ST_IDLE;
                  batchSent_d = 1'b1;
                  nextOp      = ST_IDLE;
                end else begin
                  resume_d = ST_FETCH;
                  nextOp   = ST_FETCH;
                end
              end
              default: nextOp = ST_IDLE;
            endcase
            state_d = run_i ? nextOp : ST_IDLE;
            phase_d = PH_REQ;
            toCnt_d = '0;
          end

          default: phase_d = PH_REQ;
        endcase
      end
    endcase
  end

  // Tick bookkeeping and sticky error flags; a same-cycle set beats clear.
  always_comb begin
    overrunSet = tick && tickPend_q && !enterSense;
    tickPend_d = tickPend_q;
    if (tick) begin
      tickPend_d = 1'b1;
    end else if (enterSense) begin
      tickPend_d = 1'b0;
    end

    overrun_d = overrun_q;
    if (overrunSet) begin
      overrun_d = 1'b1;
    end else if (clear_err_i) begin
      overrun_d = 1'b0;
    end

    timeoutErr_d = timeoutErr_q;
    if (timeoutSet) begin
      timeoutErr_d = 1'b1;
    end else if (clear_err_i) begin
      timeoutErr_d = 1'b0;
    end
  end

  // Controller-facing outputs decoded from the next state so they register cleanly.
  always_comb begin
    ctrlEnable_d = (state_d != ST_IDLE);
    schedBusy_d  = (state_d != ST_IDLE);
    ctrlInst_d   = INST_IDLE;
    if ((state_d != ST_IDLE) && (phase_d != PH_GAP)) begin
      ctrlInst_d = opCode(state_d);
    end
  end

  // Sequencer, timer and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= PH_REQ;
      resume_q     <= ST_IDLE;
      toCnt_q      <= '0;
      timer_q      <= TIMER_RELOAD;
      tickPend_q   <= 1'b0;
      storedCnt_q  <= 8'd0;
      batchSent_q  <= 1'b0;
      overrun_q    <= 1'b0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      resume_q     <= resume_d;
      toCnt_q      <= toCnt_d;
      timer_q      <= timer_d;
      tickPend_q   <= tickPend_d;
      storedCnt_q  <= storedCnt_d;
      batchSent_q  <= batchSent_d;
      overrun_q    <= overrun_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  // Registered controller interface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrlEnable_q <= 1'b0;
      schedBusy_q  <= 1'b0;
      ctrlInst_q   <= INST_IDLE;
    end else begin
      ctrlEnable_q <= ctrlEnable_d;
      schedBusy_q  <= schedBusy_d;
      ctrlInst_q   <= ctrlInst_d;
    end
  end

  assign ctrl_enable_o = ctrlEnable_q;
  assign ctrl_inst_o   = ctrlInst_q;
  assign sched_busy_o  = schedBusy_q;
  assign stored_cnt_o  = storedCnt_q;
  assign batch_sent_o  = batchSent_q;
  assign overrun_o     = overrun_q;
  assign timeout_err_o = timeoutErr_q;

endmodule

// File: tb/tb_node_scheduler.sv
// tb_node_scheduler: randomized bench for node_scheduler with a job-level
// reference model (ops held as queues) and a simple controller responder.
module tb_node_scheduler;

  localparam int SP    = 20;
  localparam int BATCH = 2;
  localparam int TW    = 16;
  localparam int STO   = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       rxPending = 1'b0;
  logic       clearErr = 1'b0;
  logic       ctrlBusy = 1'b0;
  logic       ctrlEnable;
  logic [2:0] ctrlInst;
  logic       schedBusy;
  logic [7:0] storedCnt;
  logic       batchSent;
  logic       overrun;
  logic       timeoutErr;

  int vectors = 0;
  int miscompares = 0;

  bit releaseReset = 1'b0;

  // Reference model state: the op in flight plus queued remaining ops.
  int mTimer;
  bit mTickPend;
  bit mOverrun;
  bit mTimeout;
  int mStored;
  bit mBatch;
  int mPhase;      // 0 idle, 1 request, 2 running, 3 gap
  int mOp;
  int mReqCnt;
  bit mFromFlush;
  int jobQ[$];
  int flushQ[$];

  // Controller responder state.
  int cMode;
  bit cActive;
  int cAge;
  int cDelay;
  int cHold;
  int cPrevInst;

  always #5 clk = ~clk;

  node_scheduler #(
    .SAMPLE_PERIOD(SP),
    .BATCH(BATCH),
    .TIMER_W(TW),
    .START_TIMEOUT(STO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .run_i(run),
    .rx_pending_i(rxPending),
    .clear_err_i(clearErr),
    .ctrl_busy_i(ctrlBusy),
    .ctrl_enable_o(ctrlEnable),
    .ctrl_inst_o(ctrlInst),
    .sched_busy_o(schedBusy),
    .stored_cnt_o(storedCnt),
    .batch_sent_o(batchSent),
    .overrun_o(overrun),
    .timeout_err_o(timeoutErr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic int modelInst();
    return (mPhase == 1 || mPhase == 2) ? mOp : 0;
  endfunction

  task automatic modelReset();
    mTimer     = SP - 1;
    mTickPend  = 1'b0;
    mOverrun   = 1'b0;
    mTimeout   = 1'b0;
    mStored    = 0;
    mBatch     = 1'b0;
    mPhase     = 0;
    mOp        = 0;
    mReqCnt    = 0;
    mFromFlush = 1'b0;
    jobQ.delete();
    flushQ.delete();
  endtask

  task automatic startOp(input int op, input bit fromFlush);
    mOp        = op;
    mFromFlush = fromFlush;
    mPhase     = 1;
    mReqCnt    = 0;
  endtask

  // One clock of the reference: job plans are op queues, effects applied when an op finishes.
  task automatic modelStep(input bit r, input bit rx, input bit clr, input bit busy);
    bit tick;
    bit consumed;
    bit toSet;
    bit ovSet;
    tick     = 1'b0;
    consumed = 1'b0;
    toSet    = 1'b0;
    mBatch   = 1'b0;
    if (r) begin
      if (mTimer == 0) begin
        mTimer = SP - 1;
        tick   = 1'b1;
      end else begin
        mTimer = mTimer - 1;
      end
    end
    case (mPhase)
      0: begin
        if (r) begin
          if (flushQ.size() > 0) begin
            startOp(flushQ[0], 1'b1);
          end else if (mTickPend) begin
            jobQ.delete();
            jobQ.push_back(1);
            jobQ.push_back(4);
            startOp(1, 1'b0);
            consumed = 1'b1;
          end else if (rx) begin
            jobQ.delete();
            jobQ.push_back(2);
            startOp(2, 1'b0);
          end
        end
      end
      1: begin
        if (busy) begin
          mPhase = 2;
        end else if (mReqCnt == STO - 1) begin
          toSet  = 1'b1;
          mPhase = 0;
          jobQ.delete();
        end else begin
          mReqCnt++;
        end
      end
      2: begin
        if (!busy) mPhase = 3;
      end
      default: begin
        if (mFromFlush) void'(flushQ.pop_front());
        else void'(jobQ.pop_front());
        if (mOp == 4) begin
          if (mStored < 255) mStored++;
          if (mStored == BATCH) begin
            for (int k = 0; k < BATCH; k++) begin
              flushQ.push_back(5);
              flushQ.push_back(3);
            end
          end
        end
        if (mOp == 3) begin
          mStored--;
          if (mStored == 0) mBatch = 1'b1;
        end
        if (!r) begin
          mPhase = 0;
          jobQ.delete();
        end else if (flushQ.size() > 0) begin
          startOp(flushQ[0], 1'b1);
        end else if (jobQ.size() > 0) begin
          startOp(jobQ[0], 1'b0);
        end else begin
          mPhase = 0;
        end
      end
    endcase
    ovSet = tick && mTickPend && !consumed;
    if (tick) mTickPend = 1'b1;
    else if (consumed) mTickPend = 1'b0;
    if (ovSet) mOverrun = 1'b1;
    else if (clr) mOverrun = 1'b0;
    if (toSet) mTimeout = 1'b1;
    else if (clr) mTimeout = 1'b0;
  endtask

  task automatic controllerReset();
    cActive   = 1'b0;
    cAge      = 0;
    cDelay    = 0;
    cHold     = 0;
    cPrevInst = 0;
  endtask

  // Busy responder: reacts to each new instruction after a delay and holds busy.
  task automatic controllerStep(output bit busy);
    int inst;
    int pick;
    inst = modelInst();
    if (inst == 0) begin
      cActive = 1'b0;
    end else if (cPrevInst == 0) begin
      cActive = 1'b1;
      cAge    = 0;
      pick    = cMode;
      if (cMode == 4) begin
        pick = $urandom_range(0, 19);
        pick = (pick == 0) ? 2 : ((pick == 1) ? 3 : 1);
      end
      case (pick)
        0: begin cDelay = 2; cHold = 3; end
        1: begin cDelay = $urandom_range(0, 3); cHold = $urandom_range(1, 5); end
        2: begin cDelay = -1; cHold = 0; end
        default: begin cDelay = 2; cHold = 45; end
      endcase
    end else if (cActive) begin
      cAge++;
    end
    cPrevInst = inst;
    busy = cActive && (cDelay >= 0) && (cAge >= cDelay) && (cAge < cDelay + cHold);
  endtask

  task automatic checkAll();
    checkOutput("ctrl_enable", ctrlEnable, mPhase != 0);
    checkOutput("ctrl_inst", ctrlInst, modelInst());
    checkOutput("sched_busy", schedBusy, mPhase != 0);
    checkOutput("stored_cnt", storedCnt, mStored);
    checkOutput("batch_sent", batchSent, mBatch);
    checkOutput("overrun", overrun, mOverrun);
    checkOutput("timeout_err", timeoutErr, mTimeout);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_enable"}, ctrlEnable, 0);
    checkOutput({tag, "_inst"}, ctrlInst, 0);
    checkOutput({tag, "_busy"}, schedBusy, 0);
    checkOutput({tag, "_stored"}, storedCnt, 0);
    checkOutput({tag, "_batch"}, batchSent, 0);
    checkOutput({tag, "_overrun"}, overrun, 0);
    checkOutput({tag, "_timeout"}, timeoutErr, 0);
  endtask

  task automatic applyStimulus(input bit r, input bit rx, input bit clr);
    bit b;
    @(negedge clk);
    if (releaseReset) begin
      rst_n        = 1'b1;
      releaseReset = 1'b0;
    end
    controllerStep(b);
    run       = r;
    rxPending = rx;
    clearErr  = clr;
    ctrlBusy  = b;
    @(posedge clk);
    modelStep(r, rx, clr, b);
    #1;
    checkAll();
  endtask

  initial begin
    bit r;
    int waited;
    modelReset();
    controllerReset();
    repeat (3) @(negedge clk);
    checkResetValues("por");
    releaseReset = 1'b1;

    // Plain sampling and batch flush with a well-behaved controller.
    cMode = 0;
    repeat (120) applyStimulus(1'b1, 1'b0, 1'b0);

    // Radio receive traffic interleaved with sample ticks.
    repeat (150) applyStimulus(1'b1, $urandom_range(0, 3) == 0, 1'b0);

    // Controller never answers: start timeouts.
    cMode = 2;
    repeat (60) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("timeoutSticky", timeoutErr, 1);
    cMode = 0;
    repeat (40) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);

    // Long busy holds force overruns.
    cMode = 3;
    repeat (150) applyStimulus(1'b1, 1'b0, 1'b0);

    // Random run, receive and clear traffic with a mixed controller.
    cMode = 4;
    r = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 24) == 0) r = ~r;
      applyStimulus(r, $urandom_range(0, 4) == 0, $urandom_range(0, 30) == 0);
    end

    // Asynchronous reset while a WRITE_RADIO is running.
    cMode = 0;
    waited = 0;
    while (!(mPhase == 2 && mOp == 3) && waited < 400) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      waited++;
    end
    checkOutput("reachSendRun", (mPhase == 2 && mOp == 3), 1);
    #2 rst_n = 1'b0;
    #1;
    checkResetValues("asyncReset");
    modelReset();
    controllerReset();
    repeat (3) @(negedge clk);
    releaseReset = 1'b1;
    repeat (80) applyStimulus(1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
